// File: rtl/lsu_mem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lsu_mem_pkg : shared types and constants for the LSU SRAM responder |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package lsu_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int          c_mask_w            = 4;
    localparam logic [31:0] c_default_base_addr = 32'h8000_0000;
    localparam logic [31:0] c_oor_rdata         = 32'h0;

    // The word index is kept beside the slot because its width follows DEPTH_WORDS.
    typedef struct packed {
        logic                valid;
        logic                wen;
        logic                in_range;
        logic [c_mask_w-1:0] wmask;
        logic [31:0]         wdata;
    } slot_t;

    localparam slot_t c_slot_empty = '0;

endpackage
`default_nettype wire

// File: rtl/lsu_sram_array.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lsu_sram_array : synchronous single-port byte-masked word RAM       |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module lsu_sram_array
    import lsu_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic                clk,
    input  logic                i_we,
    input  logic                i_re,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic [31:0]         i_wdata,
    input  logic [c_mask_w-1:0] i_wmask,
    output logic [31:0]         o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < c_mask_w; b++) begin
                if (i_wmask[b]) begin
                    r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/lsu_sram_responder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lsu_sram_responder : fixed-latency LSU data-memory responder with   |
// | one pending slot, flush squashing and sticky error flags. Rev 1.0   |
// +--------------------------------------------------------------------+
module lsu_sram_responder
    import lsu_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = c_default_base_addr,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          LATENCY     = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                mem_req,
    input  logic                mem_wen,
    input  logic [31:0]         mem_addr,
    input  logic [31:0]         mem_wdata,
    input  logic [c_mask_w-1:0] mem_wmask,
    output logic                mem_rvalid,
    output logic [31:0]         mem_rdata,
    output logic                busy,
    output logic                err_range,
    output logic                err_overlap
);

    localparam int                 c_aw         = $clog2(DEPTH_WORDS);
    localparam int                 c_cnt_w      = $clog2(LATENCY + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_load   = c_cnt_w'(LATENCY - 1);
    localparam state_t             c_load_state = (LATENCY == 1) ? ST_RESP : ST_WAIT;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_cnt_w-1:0]  w_cnt_nxt;

    slot_t               r_cur;
    slot_t               r_pend;
    logic [c_aw-1:0]     r_cur_idx;
    logic [c_aw-1:0]     r_pend_idx;
    slot_t               w_cur_nxt;
    slot_t               w_pend_nxt;
    logic [c_aw-1:0]     w_cur_idx_nxt;
    logic [c_aw-1:0]     w_pend_idx_nxt;

    logic                r_rvalid;
    logic                r_rdata_zero;
    logic                r_err_range;
    logic                r_err_overlap;

    logic [31:0]         w_off;
    logic                w_new_in_range;
    logic [c_aw-1:0]     w_new_idx;
    slot_t               w_new_slot;
    logic                w_cur_free;
    logic                w_load_cur;
    logic                w_overlap;

    slot_t               w_exec;
    logic [c_aw-1:0]     w_exec_idx;
    logic                w_enter_resp;
    logic                w_ram_we;
    logic                w_ram_re;
    logic                w_set_err_range;
    logic [31:0]         w_ram_q;

    // Widened compare so the top of the window cannot wrap past 2^32.
    assign w_off          = mem_addr - BASE_ADDR;
    assign w_new_in_range = (mem_addr >= BASE_ADDR) &&
                            ({2'b00, w_off} < (34'(DEPTH_WORDS) << 2));
    assign w_new_idx      = w_off[c_aw+1:2];

    always_comb begin
        w_new_slot          = c_slot_empty;
        w_new_slot.valid    = 1'b1;
        w_new_slot.wen      = mem_wen;
        w_new_slot.in_range = w_new_in_range;
        w_new_slot.wmask    = mem_wmask;
        w_new_slot.wdata    = mem_wdata;
    end

    assign w_cur_free = !r_cur.valid || (r_state == ST_RESP);

    // Slot allocation: retire, promote PEND, then place the new request.
    always_comb begin
        w_cur_nxt      = r_cur;
        w_cur_idx_nxt  = r_cur_idx;
        w_pend_nxt     = r_pend;
        w_pend_idx_nxt = r_pend_idx;
        w_load_cur     = 1'b0;
        w_overlap      = 1'b0;
        if (flush) begin
            w_cur_nxt  = c_slot_empty;
            w_pend_nxt = c_slot_empty;
        end else if (w_cur_free) begin
            if (r_pend.valid) begin
                w_cur_nxt     = r_pend;
                w_cur_idx_nxt = r_pend_idx;
                w_load_cur    = 1'b1;
                if (mem_req) begin
                    w_pend_nxt     = w_new_slot;
                    w_pend_idx_nxt = w_new_idx;
                end else begin
                    w_pend_nxt = c_slot_empty;
                end
            end else if (mem_req) begin
                w_cur_nxt     = w_new_slot;
                w_cur_idx_nxt = w_new_idx;
                w_load_cur    = 1'b1;
            end else begin
                w_cur_nxt = c_slot_empty;
            end
        end else if (mem_req) begin
            if (r_pend.valid) begin
                w_overlap = 1'b1;
            end else begin
                w_pend_nxt     = w_new_slot;
                w_pend_idx_nxt = w_new_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (flush) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_load_cur) begin
                        w_state_nxt = c_load_state;
                        w_cnt_nxt   = c_cnt_load;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt <= c_cnt_w'(1)) begin
                        w_state_nxt = ST_RESP;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt - c_cnt_w'(1);
                    end
                end
                ST_RESP: begin
                    if (w_load_cur) begin
                        w_state_nxt = c_load_state;
                        w_cnt_nxt   = c_cnt_load;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // With LATENCY=1 the slot entering RESP is the one being loaded this edge.
    always_comb begin
        w_exec          = w_load_cur ? w_cur_nxt : r_cur;
        w_exec_idx      = w_load_cur ? w_cur_idx_nxt : r_cur_idx;
        w_enter_resp    = (w_state_nxt == ST_RESP) && w_exec.valid;
        w_ram_we        = w_enter_resp &&  w_exec.wen && w_exec.in_range;
        w_ram_re        = w_enter_resp && !w_exec.wen && w_exec.in_range;
        w_set_err_range = w_enter_resp && !w_exec.in_range;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cur         <= c_slot_empty;
            r_pend        <= c_slot_empty;
            r_cur_idx     <= '0;
            r_pend_idx    <= '0;
            r_rvalid      <= 1'b0;
            r_rdata_zero  <= 1'b1;
            r_err_range   <= 1'b0;
            r_err_overlap <= 1'b0;
        end else begin
            r_cur      <= w_cur_nxt;
            r_pend     <= w_pend_nxt;
            r_cur_idx  <= w_cur_idx_nxt;
            r_pend_idx <= w_pend_idx_nxt;
            r_rvalid   <= w_enter_resp;
            if (w_enter_resp) begin
                r_rdata_zero <= !w_ram_re;
            end
            if (w_set_err_range) begin
                r_err_range <= 1'b1;
            end
            if (w_overlap) begin
                r_err_overlap <= 1'b1;
            end
        end
    end

    lsu_sram_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (c_aw)
    ) u_array (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_re    (w_ram_re),
        .i_addr  (w_exec_idx),
        .i_wdata (w_exec.wdata),
        .i_wmask (w_exec.wmask),
        .o_rdata (w_ram_q)
    );

    // The RAM output register only moves on loads; stores and misses show zero.
    assign mem_rdata   = r_rdata_zero ? c_oor_rdata : w_ram_q;
    assign mem_rvalid  = r_rvalid;
    assign busy        = r_cur.valid | r_pend.valid;
    assign err_range   = r_err_range;
    assign err_overlap = r_err_overlap;

endmodule
`default_nettype wire

// File: tb/tb_lsu_sram_responder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_lsu_sram_responder : directed bench, LATENCY=2 and LATENCY=4 DUTs |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_lsu_sram_responder;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        a_flush, a_req, a_wen;
    logic [31:0] a_addr, a_wdata;
    logic [3:0]  a_wmask;
    logic        a_rvalid, a_busy, a_err_range, a_err_overlap;
    logic [31:0] a_rdata;

    logic        b_flush, b_req, b_wen;
    logic [31:0] b_addr, b_wdata;
    logic [3:0]  b_wmask;
    logic        b_rvalid, b_busy, b_err_range, b_err_overlap;
    logic [31:0] b_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    lsu_sram_responder #(.LATENCY(2)) u_dut_a (
        .clk (clk), .rst (rst), .flush (a_flush),
        .mem_req (a_req), .mem_wen (a_wen), .mem_addr (a_addr),
        .mem_wdata (a_wdata), .mem_wmask (a_wmask),
        .mem_rvalid (a_rvalid), .mem_rdata (a_rdata), .busy (a_busy),
        .err_range (a_err_range), .err_overlap (a_err_overlap)
    );

    lsu_sram_responder #(.LATENCY(4)) u_dut_b (
        .clk (clk), .rst (rst), .flush (b_flush),
        .mem_req (b_req), .mem_wen (b_wen), .mem_addr (b_addr),
        .mem_wdata (b_wdata), .mem_wmask (b_wmask),
        .mem_rvalid (b_rvalid), .mem_rdata (b_rdata), .busy (b_busy),
        .err_range (b_err_range), .err_overlap (b_err_overlap)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds a one-cycle request on DUT A; returns one cycle later.
    task automatic a_issue(input logic wen, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] mask);
        a_req   = 1'b1;
        a_wen   = wen;
        a_addr  = addr;
        a_wdata = data;
        a_wmask = mask;
        step();
        a_req   = 1'b0;
    endtask

    initial begin
        int seen;
        rst = 1'b1;
        a_flush = 0; a_req = 0; a_wen = 0; a_addr = 0; a_wdata = 0; a_wmask = 0;
        b_flush = 0; b_req = 0; b_wen = 0; b_addr = 0; b_wdata = 0; b_wmask = 0;
        step();
        step();
        chk("rst_rvalid", a_rvalid, 0);
        chk("rst_rdata", a_rdata, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_err_range", a_err_range, 0);
        chk("rst_err_overlap", a_err_overlap, 0);
        chk("rst_b_busy", b_busy, 0);
        rst = 1'b0;
        step();

        // SW then LW same word
        a_issue(1'b1, 32'h8000_0010, 32'h1234_5678, 4'b1111);
        chk("sw_c1_rvalid", a_rvalid, 0);
        chk("sw_c1_busy", a_busy, 1);
        step();
        chk("sw_c2_rvalid", a_rvalid, 1);
        chk("sw_c2_rdata", a_rdata, 0);
        a_issue(1'b0, 32'h8000_0010, 32'h0, 4'b0000);
        chk("lw_c3_rvalid", a_rvalid, 0);
        step();
        chk("lw_c4_rvalid", a_rvalid, 1);
        chk("lw_c4_rdata", a_rdata, 32'h1234_5678);
        step();
        chk("lw_c5_rvalid", a_rvalid, 0);
        chk("lw_c5_rdata_held", a_rdata, 32'h1234_5678);
        chk("lw_c5_busy", a_busy, 0);

        // byte store into lane 2
        a_issue(1'b1, 32'h8000_0012, 32'h00AB_0000, 4'b0100);
        step();
        a_issue(1'b0, 32'h8000_0010, 32'h0, 4'b0000);
        step();
        chk("sb_lw_rvalid", a_rvalid, 1);
        chk("sb_lw_rdata", a_rdata, 32'h12AB_5678);
        step();

        // last in-range word
        a_issue(1'b1, 32'h8000_3FFC, 32'hA5A5_0F0F, 4'b1111);
        step();
        a_issue(1'b0, 32'h8000_3FFC, 32'h0, 4'b0000);
        step();
        chk("top_word_rdata", a_rdata, 32'hA5A5_0F0F);
        chk("top_word_err_range", a_err_range, 0);
        step();

        // flush squashes an in-flight store
        a_issue(1'b1, 32'h8000_0020, 32'hCAFE_F00D, 4'b1111);
        step();
        step();
        a_issue(1'b1, 32'h8000_0020, 32'hDEAD_BEEF, 4'b1111);
        a_flush = 1'b1;
        chk("flush_c1_busy", a_busy, 1);
        step();
        a_flush = 1'b0;
        chk("flush_c2_rvalid", a_rvalid, 0);
        chk("flush_c2_busy", a_busy, 0);
        a_issue(1'b0, 32'h8000_0020, 32'h0, 4'b0000);
        step();
        chk("flush_lw_rvalid", a_rvalid, 1);
        chk("flush_lw_old_word", a_rdata, 32'hCAFE_F00D);
        step();

        // out-of-range below base, then one word past the top
        a_issue(1'b1, 32'h8000_0000, 32'h0BAD_F00D, 4'b1111);
        step();
        chk("oor_pre_err_range", a_err_range, 0);
        a_issue(1'b0, 32'h7FFF_FFFC, 32'h0, 4'b0000);
        chk("oor_c1_err_range", a_err_range, 0);
        step();
        chk("oor_c2_rvalid", a_rvalid, 1);
        chk("oor_c2_rdata", a_rdata, 32'h0);
        chk("oor_c2_err_range", a_err_range, 1);
        step();
        a_issue(1'b1, 32'h8000_4000, 32'h1111_1111, 4'b1111);
        step();
        a_issue(1'b0, 32'h8000_0000, 32'h0, 4'b0000);
        step();
        chk("oor_store_no_alias", a_rdata, 32'h0BAD_F00D);
        chk("oor_sticky", a_err_range, 1);
        chk("no_overlap_a", a_err_overlap, 0);
        step();

        // LATENCY=4: three back-to-back loads, third dropped
        b_req = 1'b1; b_wen = 1'b0; b_addr = 32'h8000_0000;
        step();
        step();
        chk("b_c2_overlap", b_err_overlap, 0);
        step();
        b_req = 1'b0;
        chk("b_c3_overlap", b_err_overlap, 1);
        chk("b_c3_rvalid", b_rvalid, 0);
        step();
        chk("b_c4_rvalid", b_rvalid, 1);
        step();
        chk("b_c5_rvalid", b_rvalid, 0);
        step();
        step();
        chk("b_c7_rvalid", b_rvalid, 0);
        step();
        chk("b_c8_rvalid", b_rvalid, 1);
        chk("b_c8_busy", b_busy, 1);
        step();
        chk("b_c9_busy", b_busy, 0);
        chk("b_c9_rvalid", b_rvalid, 0);
        chk("b_c9_overlap_sticky", b_err_overlap, 1);

        // async reset mid-WAIT
        a_issue(1'b0, 32'h8000_0010, 32'h0, 4'b0000);
        chk("rstw_busy_before", a_busy, 1);
        rst = 1'b1;
        #1;
        chk("rstw_busy", a_busy, 0);
        chk("rstw_rvalid", a_rvalid, 0);
        chk("rstw_rdata", a_rdata, 0);
        chk("rstw_err_range", a_err_range, 0);
        step();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (a_rvalid) seen++;
        end
        chk("rstw_no_late_resp", seen, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lsu_sram_responder.md
# lsu_sram_responder

Responder end of the pipeline LSU data-memory port: accepts single-cycle `mem_req` pulses and returns one `mem_rvalid` pulse per accepted request after a fixed, parameterised latency. Backs the port with a byte-masked word SRAM. Provides a one-entry pending slot, flush squashing and sticky error flags. Used as the data memory for the pipeline in simulation and FPGA builds.

## Interface
- `BASE_ADDR`, 32'h8000_0000: byte address of word 0.
- `DEPTH_WORDS`, 4096: number of 32-bit words (power of two).
- `LATENCY`, 2: cycles from request to response, ≥1.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `flush`  in  1  pipeline flush; squashes all outstanding requests.
- `mem_req`  in  1  request pulse; sampled every cycle.
- `mem_wen`  in  1  1 = store, 0 = load.
- `mem_addr`  in  32  byte address; `[1:0]` ignored for indexing.
- `mem_wdata`  in  32  store data, already lane-aligned by the initiator.
- `mem_wmask`  in  4  byte-lane write enables.
- `mem_rvalid`  out  1  one-cycle response pulse, for loads and for stores.
- `mem_rdata`  out  32  load data, valid with `mem_rvalid`.
- `busy`  out  1  current or pending request outstanding.
- `err_range`  out  1  sticky flag: an out-of-range access was made.
- `err_overlap`  out  1  sticky flag: a request was dropped because both slots were full.

## Operation
- Two request slots, CUR and PEND, each holding {valid, wen, word index, wdata, wmask, in_range}.
- In-range test: `addr >= BASE_ADDR && ((addr-BASE_ADDR)>>2) < DEPTH_WORDS`.
- Word index is `(addr-BASE_ADDR)[clog2(DEPTH_WORDS)+1:2]`.
- CUR state machine:
  - IDLE: load a request into CUR, go to WAIT with `cnt = LATENCY-1`.
  - WAIT: decrement `cnt`; at 0, go to RESP.
  - RESP: `mem_rvalid` = 1 for this cycle only. Next state is WAIT if PEND is valid or a new request arrives, otherwise IDLE.
- Store: the masked write occurs at the edge entering RESP. `mem_rdata` is driven to 0.
- Load: the array is read at the edge entering RESP, so it sees all earlier writes. `mem_rdata` is registered and held until the next response.
- Out-of-range request:
  - Write is suppressed and `mem_rdata` = 0.
  - `err_range` is set at the edge entering RESP, so it rises in the same cycle as `mem_rvalid`.
- Slot allocation at each edge:
  1. CUR retires if in RESP.
  2. PEND moves to CUR if CUR is free.
  3. An incoming `mem_req` takes the first free slot, CUR before PEND.
  4. If no slot is free, the request is dropped and `err_overlap` is set.
  - A request that moves from PEND to CUR starts its LATENCY count at that edge.
- `busy` = CUR.valid | PEND.valid.
- Flush (edge with `flush`=1):
  - Both slots are invalidated, state goes to IDLE and `cnt` is cleared.
  - A `mem_req` in the same cycle is dropped.
  - A write due at that edge is not performed; flush wins.
  - Sticky flags are unchanged.
  - If `mem_rvalid` is already high in the flush cycle, that response stands.
- Reset:
  - All registers clear: `mem_rvalid`, `mem_rdata`, `busy`, `err_range` and `err_overlap` reset to 0, state to IDLE.
  - SRAM contents are not reset.

## Timing
- `mem_req` in cycle n (slot free) → `mem_rvalid` in cycle n+LATENCY.
- PEND is promoted in the retire cycle r → its response is in cycle r+LATENCY.
- Minimum response spacing is LATENCY cycles.
- `mem_rvalid` is never high for two consecutive cycles when LATENCY > 1.
- With LATENCY=1, back-to-back requests give back-to-back pulses.
- All outputs are registered except `busy`.
- Asynchronous `rst` drops all outputs immediately; no response is emitted after release for pre-reset requests.

## Structure
- Package `lsu_mem_pkg` holds:
  - the state enum {IDLE, WAIT, RESP};
  - the slot struct typedef;
  - the default `BASE_ADDR`;
  - the mask width (4) and the out-of-range read value (32'h0).
- Sub-module `lsu_sram_array`: synchronous single-port, byte-masked word RAM, `DEPTH_WORDS` × 32, one read or write per cycle.
- Counter width is `$clog2(LATENCY+1)`.

## Test plan
All scenarios use LATENCY=2 and the default BASE_ADDR unless stated.
- SW 0x1234_5678, mask 1111, to 0x8000_0010 in cycle 0, then LW from the same address in cycle 2:
  - `mem_rvalid` in cycles 2 and 4;
  - `mem_rdata` = 0 in cycle 2 and 0x1234_5678 in cycle 4.
- SB to 0x8000_0012 with wdata 0x00AB_0000 and mask 0100 over the word 0x1234_5678, then LW → 0x12AB_5678.
- LATENCY=4, loads requested in cycles 0, 1 and 2:
  - responses in cycles 4 and 8;
  - the cycle-2 request is dropped;
  - `err_overlap` = 1 from cycle 3;
  - `busy` = 0 from cycle 9.
- SW to 0x8000_0020 in cycle 0, `flush` in cycle 1:
  - no `mem_rvalid` in cycle 2;
  - `busy` = 0 from cycle 2;
  - a later LW returns the old word.
- LW from 0x7FFF_FFFC in cycle 0 → `mem_rvalid` in cycle 2 with `mem_rdata` = 0; `err_range` = 1 from cycle 2 and stays set.
- `rst` asserted mid-WAIT → `busy` and `mem_rvalid` go low immediately; no response appears after `rst` is released.
